// File: rtl/core_ma_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  core_ma_pkg : shared types and helpers for the memory-access stage
//  Rev 1.0
// ============================================================================
package core_ma_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10,
      MEM_D = 2'b11
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_OUT    = 2'd3
   } lsu_state_e;

   function automatic logic [7:0] size_mask(input mem_op_e op);
      logic [7:0] m;
      case (op)
         MEM_B:   m = 8'h01;
         MEM_H:   m = 8'h03;
         MEM_W:   m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input mem_op_e op, input logic [2:0] addr_lo);
      logic mis;
      case (op)
         MEM_B:   mis = 1'b0;
         MEM_H:   mis = addr_lo[0];
         MEM_W:   mis = |addr_lo[1:0];
         default: mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_ma_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  core_ma_align : store lane steering, byte enables, load extract/extend
//  Rev 1.0
// ============================================================================
module core_ma_align
   import core_ma_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int BE_W   = DATA_W / 8,
   localparam int LANE_W = $clog2(BE_W)
) (
   input  logic [1:0]        op_i,
   input  logic [LANE_W-1:0] lane_i,
   input  logic              unsigned_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic [BE_W-1:0]   byte_en_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic [DATA_W-1:0] load_result_o
);

   mem_op_e           w_op;
   logic [LANE_W+2:0] w_bit_off;
   logic [DATA_W-1:0] w_shifted;
   logic              w_sign;

   assign w_op         = mem_op_e'(op_i);
   assign w_bit_off    = {lane_i, 3'b000};
   assign byte_en_o    = BE_W'(size_mask(w_op)) << lane_i;
   assign write_data_o = store_data_i << w_bit_off;
   assign w_shifted    = load_data_i >> w_bit_off;

   // Bring the addressed lane down to bit 0, then fill everything above the access size.
   always_comb begin
      w_sign        = 1'b0;
      load_result_o = w_shifted;
      case (w_op)
         MEM_B: begin
            w_sign = ~unsigned_i & w_shifted[7];
            for (int i = 8; i < DATA_W; i++) load_result_o[i] = w_sign;
         end
         MEM_H: begin
            w_sign = ~unsigned_i & w_shifted[15];
            for (int i = 16; i < DATA_W; i++) load_result_o[i] = w_sign;
         end
         MEM_W: begin
            w_sign = ~unsigned_i & w_shifted[31];
            for (int i = 32; i < DATA_W; i++) load_result_o[i] = w_sign;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/core_ma_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  core_ma_lsu : memory-access stage between ex and wb with sub-word bus access
//  Rev 1.0
// ============================================================================
module core_ma_lsu
   import core_ma_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 32,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              em_valid,
   output logic              em_ready,
   input  logic [ADDR_W-1:0] em_reg_data_mem_addr,
   input  logic [DATA_W-1:0] em_csr_data_mem_data,
   input  logic              em_mem_read,
   input  logic              em_mem_write,
   input  logic [1:0]        em_mem_op_type,
   input  logic              em_mem_unsigned,
   input  logic [4:0]        em_rd,
   input  logic              em_reg_write,
   input  logic [11:0]       em_csr,
   input  logic              em_csr_write,
   output logic              mw_valid,
   input  logic              mw_ready,
   output logic [DATA_W-1:0] mw_reg_data,
   output logic [DATA_W-1:0] mw_csr_data,
   output logic [4:0]        mw_rd,
   output logic              mw_reg_write,
   output logic [11:0]       mw_csr,
   output logic              mw_csr_write,
   output logic              mw_misaligned,
   output logic [ADDR_W-1:0] avl_address,
   output logic [BE_W-1:0]   avl_byte_en,
   output logic              avl_read,
   output logic              avl_write,
   output logic [DATA_W-1:0] avl_write_data,
   input  logic              avl_waitrequest,
   input  logic [DATA_W-1:0] avl_read_data,
   input  logic              avl_read_data_valid
);

   localparam int LANE_W = $clog2(BE_W);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   mem_op_e           req_op_q, req_op_d;
   logic              req_unsigned_q, req_unsigned_d;
   logic              req_read_q, req_read_d;

   logic              mw_valid_q, mw_valid_d;
   logic [DATA_W-1:0] mw_reg_data_q, mw_reg_data_d;
   logic [DATA_W-1:0] mw_csr_data_q, mw_csr_data_d;
   logic [4:0]        mw_rd_q, mw_rd_d;
   logic              mw_reg_write_q, mw_reg_write_d;
   logic [11:0]       mw_csr_q, mw_csr_d;
   logic              mw_csr_write_q, mw_csr_write_d;
   logic              mw_misaligned_q, mw_misaligned_d;

   mem_op_e           w_op;
   logic              w_is_mem;
   logic              w_mis;
   logic              w_accept;
   logic [BE_W-1:0]   w_byte_en;
   logic [DATA_W-1:0] w_load_result;

   // OUT is IDLE with a memory result held, so a wb handshake and the next accept share a cycle.
   assign em_ready = ((state_q == ST_IDLE) || (state_q == ST_OUT)) && (!mw_valid_q || mw_ready);

   always_comb begin
      state_d         = state_q;
      req_addr_d      = req_addr_q;
      req_data_d      = req_data_q;
      req_op_d        = req_op_q;
      req_unsigned_d  = req_unsigned_q;
      req_read_d      = req_read_q;
      mw_valid_d      = mw_valid_q;
      mw_reg_data_d   = mw_reg_data_q;
      mw_csr_data_d   = mw_csr_data_q;
      mw_rd_d         = mw_rd_q;
      mw_reg_write_d  = mw_reg_write_q;
      mw_csr_d        = mw_csr_q;
      mw_csr_write_d  = mw_csr_write_q;
      mw_misaligned_d = mw_misaligned_q;

      w_op = mem_op_e'(em_mem_op_type);
      if (DATA_W == 32 && w_op == MEM_D) w_op = MEM_W;
      w_is_mem = em_mem_read | em_mem_write;
      w_mis    = w_is_mem & is_misaligned(w_op, em_reg_data_mem_addr[2:0]);
      w_accept = em_valid & em_ready;

      if (mw_valid_q && mw_ready) mw_valid_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_OUT: begin
            if (mw_ready) state_d = ST_IDLE;
            if (w_accept) begin
               mw_rd_d         = em_rd;
               mw_csr_d        = em_csr;
               mw_csr_write_d  = em_csr_write;
               mw_csr_data_d   = em_csr_data_mem_data;
               mw_misaligned_d = w_mis;
               mw_reg_write_d  = em_reg_write & ~w_mis;
               if (w_is_mem && !w_mis) begin
                  req_addr_d     = em_reg_data_mem_addr;
                  req_data_d     = em_csr_data_mem_data;
                  req_op_d       = w_op;
                  req_unsigned_d = em_mem_unsigned;
                  req_read_d     = em_mem_read;
                  state_d        = ST_REQ;
               end else begin
                  mw_valid_d    = 1'b1;
                  mw_reg_data_d = DATA_W'(em_reg_data_mem_addr);
                  state_d       = ST_IDLE;
               end
            end
         end
         ST_REQ: begin
            if (!avl_waitrequest) begin
               if (req_read_q) begin
                  state_d = ST_RDWAIT;
               end else begin
                  mw_valid_d    = 1'b1;
                  mw_reg_data_d = '0;
                  state_d       = ST_OUT;
               end
            end
         end
         ST_RDWAIT: begin
            if (avl_read_data_valid) begin
               mw_valid_d    = 1'b1;
               mw_reg_data_d = w_load_result;
               state_d       = ST_OUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         req_addr_q      <= '0;
         req_data_q      <= '0;
         req_op_q        <= MEM_B;
         req_unsigned_q  <= 1'b0;
         req_read_q      <= 1'b0;
         mw_valid_q      <= 1'b0;
         mw_reg_data_q   <= '0;
         mw_csr_data_q   <= '0;
         mw_rd_q         <= '0;
         mw_reg_write_q  <= 1'b0;
         mw_csr_q        <= '0;
         mw_csr_write_q  <= 1'b0;
         mw_misaligned_q <= 1'b0;
      end else begin
         req_addr_q      <= req_addr_d;
         req_data_q      <= req_data_d;
         req_op_q        <= req_op_d;
         req_unsigned_q  <= req_unsigned_d;
         req_read_q      <= req_read_d;
         mw_valid_q      <= mw_valid_d;
         mw_reg_data_q   <= mw_reg_data_d;
         mw_csr_data_q   <= mw_csr_data_d;
         mw_rd_q         <= mw_rd_d;
         mw_reg_write_q  <= mw_reg_write_d;
         mw_csr_q        <= mw_csr_d;
         mw_csr_write_q  <= mw_csr_write_d;
         mw_misaligned_q <= mw_misaligned_d;
      end
   end

   core_ma_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .op_i          (req_op_q),
      .lane_i        (req_addr_q[LANE_W-1:0]),
      .unsigned_i    (req_unsigned_q),
      .store_data_i  (req_data_q),
      .load_data_i   (avl_read_data),
      .byte_en_o     (w_byte_en),
      .write_data_o  (avl_write_data),
      .load_result_o (w_load_result)
   );

   // Strobes decode straight from registered state so an async reset drops them at once.
   assign avl_read    = (state_q == ST_REQ) &  req_read_q;
   assign avl_write   = (state_q == ST_REQ) & ~req_read_q;
   assign avl_byte_en = (state_q == ST_REQ) ? w_byte_en : '0;
   assign avl_address = {req_addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

   assign mw_valid      = mw_valid_q;
   assign mw_reg_data   = mw_reg_data_q;
   assign mw_csr_data   = mw_csr_data_q;
   assign mw_rd         = mw_rd_q;
   assign mw_reg_write  = mw_reg_write_q;
   assign mw_csr        = mw_csr_q;
   assign mw_csr_write  = mw_csr_write_q;
   assign mw_misaligned = mw_misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_core_ma_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_core_ma_lsu : scoreboard bench for core_ma_lsu (DATA_W=32)
//  Rev 1.0
// ============================================================================
module tb_core_ma_lsu;

   logic        clk = 1'b0;
   logic        rest = 1'b0;
   logic        em_valid = 1'b0;
   logic        em_ready;
   logic [31:0] em_reg_data_mem_addr = '0;
   logic [31:0] em_csr_data_mem_data = '0;
   logic        em_mem_read = 1'b0;
   logic        em_mem_write = 1'b0;
   logic [1:0]  em_mem_op_type = '0;
   logic        em_mem_unsigned = 1'b0;
   logic [4:0]  em_rd = '0;
   logic        em_reg_write = 1'b0;
   logic [11:0] em_csr = '0;
   logic        em_csr_write = 1'b0;
   logic        mw_valid;
   logic        mw_ready = 1'b1;
   logic [31:0] mw_reg_data;
   logic [31:0] mw_csr_data;
   logic [4:0]  mw_rd;
   logic        mw_reg_write;
   logic [11:0] mw_csr;
   logic        mw_csr_write;
   logic        mw_misaligned;
   logic [31:0] avl_address;
   logic [3:0]  avl_byte_en;
   logic        avl_read;
   logic        avl_write;
   logic [31:0] avl_write_data;
   logic        avl_waitrequest = 1'b0;
   logic [31:0] avl_read_data = '0;
   logic        avl_read_data_valid = 1'b0;

   core_ma_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk                  (clk),
      .rest                 (rest),
      .em_valid             (em_valid),
      .em_ready             (em_ready),
      .em_reg_data_mem_addr (em_reg_data_mem_addr),
      .em_csr_data_mem_data (em_csr_data_mem_data),
      .em_mem_read          (em_mem_read),
      .em_mem_write         (em_mem_write),
      .em_mem_op_type       (em_mem_op_type),
      .em_mem_unsigned      (em_mem_unsigned),
      .em_rd                (em_rd),
      .em_reg_write         (em_reg_write),
      .em_csr               (em_csr),
      .em_csr_write         (em_csr_write),
      .mw_valid             (mw_valid),
      .mw_ready             (mw_ready),
      .mw_reg_data          (mw_reg_data),
      .mw_csr_data          (mw_csr_data),
      .mw_rd                (mw_rd),
      .mw_reg_write         (mw_reg_write),
      .mw_csr               (mw_csr),
      .mw_csr_write         (mw_csr_write),
      .mw_misaligned        (mw_misaligned),
      .avl_address          (avl_address),
      .avl_byte_en          (avl_byte_en),
      .avl_read             (avl_read),
      .avl_write            (avl_write),
      .avl_write_data       (avl_write_data),
      .avl_waitrequest      (avl_waitrequest),
      .avl_read_data        (avl_read_data),
      .avl_read_data_valid  (avl_read_data_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        mis;
      logic        rw;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_res(input logic [31:0] d, input logic [4:0] rd, input logic mis, input logic rw);
      exp_t e;
      e.data = d;
      e.rd   = rd;
      e.mis  = mis;
      e.rw   = rw;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every wb handshake must match the oldest expected result.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rest && mw_valid && mw_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got rd=%0d data=0x%0h, expected no result", mw_rd, mw_reg_data);
         end else begin
            e = exp_q.pop_front();
            check("res_data", mw_reg_data, e.data);
            check("res_rd", mw_rd, e.rd);
            check("res_misaligned", mw_misaligned, e.mis);
            check("res_reg_write", mw_reg_write, e.rw);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op,
                        input logic rd_en, input logic wr_en, input logic uns,
                        input logic [4:0] rd, input logic rw);
      em_valid             = 1'b1;
      em_reg_data_mem_addr = addr;
      em_csr_data_mem_data = data;
      em_mem_op_type       = op;
      em_mem_read          = rd_en;
      em_mem_write         = wr_en;
      em_mem_unsigned      = uns;
      em_rd                = rd;
      em_reg_write         = rw;
      em_csr               = 12'h000;
      em_csr_write         = 1'b0;
   endtask

   task automatic wait_accept(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = em_ready;
         step();
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s_accept: got em_ready=0 for 40 cycles, expected 1", name);
      end
      em_valid = 1'b0;
   endtask

   // Bus slave for one read with no wait states; entered right after the accepting edge.
   task automatic serve_read(input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] addr, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = avl_read;
         if (!seen) step();
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_read: got avl_read=0 for 20 cycles, expected 1", name);
      end else begin
         check({name, "_be"}, avl_byte_en, be);
         check({name, "_addr"}, avl_address, addr);
         check({name, "_no_write"}, avl_write, 1'b0);
         step();
         avl_read_data       = rdata;
         avl_read_data_valid = 1'b1;
         @(negedge clk);
         check({name, "_strobe_drop"}, avl_read, 1'b0);
         check({name, "_not_early"}, mw_valid, 1'b0);
         step();
         avl_read_data_valid = 1'b0;
         avl_read_data       = '0;
      end
   endtask

   initial begin : stimulus
      int start;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mw_valid", mw_valid, 1'b0);
      check("rst_avl_read", avl_read, 1'b0);
      check("rst_avl_write", avl_write, 1'b0);
      check("rst_byte_en", avl_byte_en, 4'h0);
      check("rst_reg_data", mw_reg_data, 32'h0);
      step();
      rest = 1'b1;
      step();

      // Non-memory op, latency 1, sideband passes through
      expect_res(32'h1234, 5'd5, 1'b0, 1'b1);
      drive(32'h1234, 32'hCAFE, 2'b10, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
      em_csr       = 12'h305;
      em_csr_write = 1'b1;
      wait_accept("nm1");
      @(negedge clk);
      check("nm1_valid", mw_valid, 1'b1);
      check("nm1_data", mw_reg_data, 32'h1234);
      check("nm1_em_ready", em_ready, 1'b1);
      check("nm1_csr", mw_csr, 12'h305);
      check("nm1_csr_write", mw_csr_write, 1'b1);
      check("nm1_csr_data", mw_csr_data, 32'hCAFE);
      step();

      // Three back-to-back non-memory ops
      start = cyc;
      expect_res(32'h10, 5'd1, 1'b0, 1'b1);
      expect_res(32'h20, 5'd2, 1'b0, 1'b1);
      expect_res(32'h30, 5'd3, 1'b0, 1'b0);
      drive(32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
      wait_accept("b2b_a");
      drive(32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
      wait_accept("b2b_b");
      drive(32'h30, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
      wait_accept("b2b_c");
      check("b2b_cycles", cyc - start, 3);
      @(negedge clk);
      #1;
      check("b2b_drained", exp_q.size(), 0);
      step();

      // SB at lane 3 with two wait states
      avl_waitrequest = 1'b1;
      expect_res(32'h0, 5'd0, 1'b0, 1'b0);
      drive(32'h103, 32'hAABBCCDD, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      wait_accept("sb");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sb_write", avl_write, 1'b1);
         check("sb_addr", avl_address, 32'h100);
         check("sb_be", avl_byte_en, 4'h8);
         check("sb_wdata_lane", avl_write_data & 32'hFF00_0000, 32'hDD00_0000);
         check("sb_em_ready", em_ready, 1'b0);
         check("sb_mw_valid", mw_valid, 1'b0);
         step();
         if (i == 1) avl_waitrequest = 1'b0;
      end
      @(negedge clk);
      check("sb_done_write", avl_write, 1'b0);
      check("sb_done_valid", mw_valid, 1'b1);
      step();

      // LH signed, then LHU with read+write both set (read wins)
      expect_res(32'hFFFF_8001, 5'd7, 1'b0, 1'b1);
      drive(32'h102, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1);
      wait_accept("lh");
      serve_read(32'h8001_5A5A, 4'hC, 32'h100, "lh");
      @(negedge clk);
      check("lh_valid", mw_valid, 1'b1);
      step();
      expect_res(32'h0000_8001, 5'd8, 1'b0, 1'b1);
      drive(32'h102, 32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1);
      wait_accept("lhu");
      serve_read(32'h8001_5A5A, 4'hC, 32'h100, "lhu");
      @(negedge clk);
      check("lhu_valid", mw_valid, 1'b1);
      step();

      // Misaligned LW: no bus access, flagged, no register write
      expect_res(32'h101, 5'd3, 1'b1, 1'b0);
      drive(32'h101, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
      wait_accept("mis");
      @(negedge clk);
      check("mis_no_read", avl_read, 1'b0);
      check("mis_valid", mw_valid, 1'b1);
      check("mis_flag", mw_misaligned, 1'b1);
      step();

      // Back-pressure on a load result, then handshake + accept in one cycle
      mw_ready = 1'b0;
      expect_res(32'hFFFF_FF9F, 5'd9, 1'b0, 1'b1);
      drive(32'h101, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1);
      wait_accept("lb");
      serve_read(32'h0000_9F00, 4'h2, 32'h100, "lb");
      expect_res(32'h55, 5'd10, 1'b0, 1'b1);
      drive(32'h55, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", mw_valid, 1'b1);
         check("stall_data", mw_reg_data, 32'hFFFF_FF9F);
         check("stall_rd", mw_rd, 5'd9);
         check("stall_em_ready", em_ready, 1'b0);
         step();
      end
      mw_ready = 1'b1;
      @(negedge clk);
      check("release_em_ready", em_ready, 1'b1);
      step();
      em_valid = 1'b0;
      @(negedge clk);
      check("release_valid", mw_valid, 1'b1);
      check("release_data", mw_reg_data, 32'h55);
      step();

      // Reset while a result is held: mw_valid drops asynchronously
      mw_ready = 1'b0;
      drive(32'h77, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
      wait_accept("r1");
      @(negedge clk);
      check("r1_pending", mw_valid, 1'b1);
      #1 rest = 1'b0;
      #1;
      check("r1_valid_drop", mw_valid, 1'b0);
      check("r1_data_clear", mw_reg_data, 32'h0);
      step();
      rest     = 1'b1;
      mw_ready = 1'b1;
      step();

      // Reset during REQ with waitrequest held: strobe drops at once
      avl_waitrequest = 1'b1;
      drive(32'h200, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 5'd11, 1'b1);
      wait_accept("r2");
      @(negedge clk);
      check("r2_read", avl_read, 1'b1);
      #1 rest = 1'b0;
      #1;
      check("r2_read_drop", avl_read, 1'b0);
      check("r2_be_drop", avl_byte_en, 4'h0);
      step();
      rest            = 1'b1;
      avl_waitrequest = 1'b0;
      step();

      // Reset during RDWAIT, then a stale read_data_valid is ignored
      drive(32'h300, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 5'd12, 1'b1);
      wait_accept("r3");
      step();
      @(negedge clk);
      check("r3_rdwait_stall", em_ready, 1'b0);
      #1 rest = 1'b0;
      #1;
      check("r3_read", avl_read, 1'b0);
      check("r3_valid", mw_valid, 1'b0);
      step();
      rest = 1'b1;
      step();
      avl_read_data       = 32'h1234_5678;
      avl_read_data_valid = 1'b1;
      step();
      avl_read_data_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("r3_late_no_valid", mw_valid, 1'b0);
         check("r3_idle_ready", em_ready, 1'b1);
         step();
      end

      repeat (2) step();
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
